// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared state encoding, widths and instruction field positions
package hack_pkg;

  localparam int ADDR_W_DEF  = 15;
  localparam int INSTR_W_DEF = 16;

  localparam int C_BIT      = 15;
  localparam int WRITEM_BIT = 3;
  localparam int J_MSB      = 2;
  localparam int J_LSB      = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEMW  = 3'd3,
    HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/hack_seq_jump_cond.sv
// rtl/hack_seq_jump_cond.sv - Hack jump predicate from j-bits and ALU flags
module jump_cond
  import hack_pkg::*;
(
  input  logic [J_MSB-J_LSB:0] j,
  input  logic                 zr,
  input  logic                 ng,
  output logic                 jump
);

  // j[2]: jump if negative, j[1]: if zero, j[0]: if strictly positive
  assign jump = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_seq.sv
// rtl/hack_seq.sv - Hack CPU fetch/execute sequencer; optional self-loop halt via HACK_SEQ_HALT_DETECT_EN
module hack_seq
  import hack_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               rom_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  input  logic [INSTR_W-1:0] a_reg,
  input  logic               zr,
  input  logic               ng,
  output logic               exec_en,
  output logic               mem_we,
  input  logic               mem_rdy,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  state_t             state;
  logic               is_c;
  logic               write_m;
  logic               cond;
  logic               jump;
  logic               commit;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_next;
  logic               unused_a_msb;

  assign is_c    = instr[C_BIT];
  assign write_m = is_c & instr[WRITEM_BIT];

  jump_cond u_jump_cond (
    .j    (instr[J_MSB:J_LSB]),
    .zr   (zr),
    .ng   (ng),
    .jump (cond)
  );

  assign jump    = is_c & cond;
  assign pc_inc  = pc + ADDR_W'(1);
  assign pc_next = jump ? a_reg[ADDR_W-1:0] : pc_inc;

  // The commit strobe must follow mem_rdy in the same cycle, so it is a decode
  // of the registered state rather than a flop of its own.
  assign commit   = ((state == EXEC) && !write_m) || ((state == MEMW) && mem_rdy);
  assign exec_en  = commit;
  assign rom_addr = pc;

  assign unused_a_msb = ^a_reg[INSTR_W-1:ADDR_W];

`ifdef HACK_SEQ_HALT_DETECT_EN
  logic prev_a;
  logic halt_hit;

  // "@N / 0;JMP" sitting at N+1 is the canonical Hack end-of-program loop
  assign halt_hit = is_c && (instr[J_MSB:J_LSB] == 3'b111) && prev_a &&
                    (a_reg[ADDR_W-1:0] == (pc - ADDR_W'(1)));
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      instr   <= '0;
      rom_req <= 1'b0;
      mem_we  <= 1'b0;
`ifdef HACK_SEQ_HALT_DETECT_EN
      prev_a  <= 1'b0;
      halted  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state   <= FETCH;
            rom_req <= 1'b1;
          end
        end
        FETCH: begin
          if (rom_ack) begin
            instr   <= rom_data;
            rom_req <= 1'b0;
            mem_we  <= rom_data[C_BIT] & rom_data[WRITEM_BIT];
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (write_m) state <= MEMW;
        end
        MEMW: begin
          if (mem_rdy) mem_we <= 1'b0;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase

      if (commit) begin
        pc <= pc_next;
`ifdef HACK_SEQ_HALT_DETECT_EN
        prev_a <= ~is_c;
        if (halt_hit) begin
          state  <= HALT;
          halted <= 1'b1;
        end else
`endif
        if (run) begin
          state   <= FETCH;
          rom_req <= 1'b1;
        end else begin
          state   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_seq.sv
// tb/tb_hack_seq.sv - table-driven self-checking bench for hack_seq
module tb_hack_seq;

  localparam int AW = 15;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          rom_ack = 1'b0;
  logic          zr = 1'b0;
  logic          ng = 1'b0;
  logic          mem_rdy = 1'b0;
  logic [IW-1:0] rom_data = '0;
  logic [IW-1:0] a_reg = '0;
  logic [IW-1:0] instr;
  logic          rom_req;
  logic          exec_en;
  logic          mem_we;
  logic          halted;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hack_seq #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .instr    (instr),
    .a_reg    (a_reg),
    .zr       (zr),
    .ng       (ng),
    .exec_en  (exec_en),
    .mem_we   (mem_we),
    .mem_rdy  (mem_rdy),
    .pc       (pc),
    .halted   (halted)
  );

  typedef struct {
    logic [15:0] ins;
    logic [15:0] a;
    logic        zr;
    logic        ng;
    int          ack_dly;
    int          rdy_dly;
    logic [14:0] exp_pc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ins, input logic [15:0] a, input logic z,
                              input logic n, input int ad, input int rd, input logic [14:0] ep);
    vec_t v;
    v.ins = ins; v.a = a; v.zr = z; v.ng = n; v.ack_dly = ad; v.rdy_dly = rd; v.exp_pc = ep;
    return v;
  endfunction

  // Serves one fetch, drives flags/mem_rdy, checks timing of the commit and the resulting pc.
  task automatic do_instr(input vec_t v, input logic [AW-1:0] cur_pc, input string tag);
    int n;
    int we_cnt;
    int commit_at;
    bit addr_ok;
    bit seen;
    bit is_we;
    is_we = v.ins[15] & v.ins[3];
    n = 0;
    while (rom_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, rom_req, 1);
    addr_ok = 1;
    for (int k = 0; k < v.ack_dly; k++) begin
      if (rom_req !== 1'b1 || rom_addr !== cur_pc) addr_ok = 0;
      @(negedge clk);
    end
    if (rom_req !== 1'b1 || rom_addr !== cur_pc) addr_ok = 0;
    check({tag, "_addr_hold"}, addr_ok, 1);
    rom_data = v.ins; rom_ack = 1'b1; a_reg = v.a; zr = v.zr; ng = v.ng; mem_rdy = 1'b0;
    @(negedge clk);
    rom_ack = 1'b0; rom_data = 16'hdead;
    check({tag, "_instr"}, instr, v.ins);
    check({tag, "_req_drop"}, rom_req, 0);
    seen = 0; we_cnt = 0; commit_at = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_we === 1'b1) begin
        mem_rdy = (we_cnt >= v.rdy_dly);
        we_cnt++;
      end
      #1;
      if (exec_en === 1'b1) begin
        seen = 1;
        commit_at = c;
      end
    end
    check({tag, "_commit_seen"}, seen, 1);
    check({tag, "_commit_cycle"}, commit_at, is_we ? v.rdy_dly + 1 : 1);
    check({tag, "_we_cycles"}, we_cnt, is_we ? v.rdy_dly + 1 : 0);
    @(negedge clk);
    mem_rdy = 1'b0;
    check({tag, "_pc"}, pc, v.exp_pc);
    check({tag, "_exec_single"}, exec_en, 0);
    check({tag, "_we_drop"}, mem_we, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] cur;
    int req_seen;

    vecs[0]  = mk(16'h0005, 16'h0000, 0, 0, 2, 1, 15'h0001);
    vecs[1]  = mk(16'hE301, 16'h0010, 0, 0, 0, 1, 15'h0010);
    vecs[2]  = mk(16'hE301, 16'h0010, 0, 1, 0, 1, 15'h0011);
    vecs[3]  = mk(16'hE302, 16'h0020, 1, 0, 1, 1, 15'h0020);
    vecs[4]  = mk(16'hE304, 16'h0030, 0, 0, 0, 1, 15'h0021);
    vecs[5]  = mk(16'hE307, 16'h7FFF, 1, 0, 0, 1, 15'h7FFF);
    vecs[6]  = mk(16'h1234, 16'h0000, 0, 0, 1, 1, 15'h0000);
    vecs[7]  = mk(16'hE308, 16'h0040, 0, 0, 0, 3, 15'h0001);
    vecs[8]  = mk(16'hE30F, 16'h8003, 0, 0, 0, 1, 15'h0003);
    vecs[9]  = mk(16'hE306, 16'h0050, 0, 0, 0, 1, 15'h0004);
    vecs[10] = mk(16'hE305, 16'h0060, 0, 0, 0, 1, 15'h0060);

    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_req", rom_req, 0);
    check("rst_exec", exec_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_halted", halted, 0);

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", rom_req, 0);
    run = 1'b1;

    cur = '0;
    for (int i = 0; i < 11; i++) begin
      do_instr(vecs[i], cur, $sformatf("v%0d", i));
      cur = vecs[i].exp_pc;
    end

    run = 1'b0;
    do_instr(mk(16'h0007, 16'h0, 0, 0, 0, 1, 15'h0061), cur, "stop");
    req_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rom_req !== 1'b0) req_seen++;
    end
    check("stop_no_req", req_seen, 0);
    check("stop_pc", pc, 15'h0061);
    run = 1'b1;
    do_instr(mk(16'h0008, 16'h0, 0, 0, 0, 1, 15'h0062), 15'h0061, "resume");

    // asynchronous reset in the middle of a fetch
    while (rom_req !== 1'b1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rfetch_pc", pc, 0);
    check("rfetch_instr", instr, 0);
    check("rfetch_req", rom_req, 0);
    check("rfetch_exec", exec_en, 0);
    check("rfetch_we", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset while waiting for the data-memory write
    do_instr(mk(16'h0009, 16'h0, 0, 0, 0, 1, 15'h0001), 15'h0000, "pre_memw");
    while (rom_req !== 1'b1) @(negedge clk);
    rom_data = 16'hE308; rom_ack = 1'b1; mem_rdy = 1'b0;
    @(negedge clk);
    rom_ack = 1'b0;
    @(negedge clk);
    check("memw_we_high", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmemw_pc", pc, 0);
    check("rmemw_instr", instr, 0);
    check("rmemw_req", rom_req, 0);
    check("rmemw_exec", exec_en, 0);
    check("rmemw_we", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // @4 at address 4, 0;JMP at address 5: the Hack end-of-program loop
    do_instr(mk(16'hE307, 16'h0004, 0, 0, 0, 1, 15'h0004), 15'h0000, "h_jmp");
    do_instr(mk(16'h0004, 16'h0004, 0, 0, 0, 1, 15'h0005), 15'h0004, "h_a");
    do_instr(mk(16'hEA87, 16'h0004, 0, 0, 0, 1, 15'h0004), 15'h0005, "h_loop");
`ifdef HACK_SEQ_HALT_DETECT_EN
    check("halt_flag", halted, 1);
    req_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rom_req !== 1'b0) req_seen++;
    end
    check("halt_no_req", req_seen, 0);
    check("halt_pc", pc, 15'h0004);
`else
    check("loop_not_halted", halted, 0);
    do_instr(mk(16'h0004, 16'h0004, 0, 0, 0, 1, 15'h0005), 15'h0004, "l_a");
    do_instr(mk(16'hEA87, 16'h0004, 0, 0, 0, 1, 15'h0004), 15'h0005, "l_loop");
    check("loop_still_running", halted, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
